// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between requesters and the regfile write ports.
// The master side raises requests and watches the ports; the arbiter is the slave side.
interface regfile_wb_arbiter_if #(
   parameter int NREQ   = 6,
   parameter int NWP    = 4,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 65
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NWP-1:0]         wp_en;
   logic [NWP*ADDR_W-1:0]  wp_addr;
   logic [NWP*DATA_W-1:0]  wp_data;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, wp_en, wp_addr, wp_data
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, wp_en, wp_addr, wp_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer regfile, with a zero-fill sequence
// that runs after reset or on init_start before any requester is accepted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-filling NWP entries per cycle, requesters held off
// ST_RUN  | granting up to NWP address-distinct requesters per cycle
module regfile_wb_arbiter #(
   parameter int NREQ   = 6,
   parameter int NWP    = 4,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 65,
   parameter int DEPTH  = 128
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  init_start,
   output logic                  init_busy,
   regfile_wb_arbiter_if.slave   bus
);
   localparam int FILL_CYC = DEPTH / NWP;
   localparam int CNT_W    = $clog2(FILL_CYC);
   localparam int RR_W     = $clog2(NREQ);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state;
   logic [CNT_W-1:0]  init_cnt;
   logic [RR_W-1:0]   rr_ptr;
   logic [RR_W-1:0]   rr_next;

   logic [ADDR_W-1:0] req_a [NREQ];
   logic [DATA_W-1:0] req_d [NREQ];

   logic [NREQ-1:0]   grant;
   logic [NWP-1:0]    slot_en;
   logic [ADDR_W-1:0] slot_a [NWP];
   logic [DATA_W-1:0] slot_d [NWP];

   int                n_gr;
   int                scan_idx;
   logic              hit;
   logic              cur_v;
   logic [ADDR_W-1:0] cur_a;
   logic [DATA_W-1:0] cur_d;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
         req_d[i] = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   // Scan from rr_ptr; the n-th grant in scan order is steered to port n.
   always_comb begin
      grant    = '0;
      slot_en  = '0;
      rr_next  = rr_ptr;
      n_gr     = 0;
      scan_idx = 0;
      hit      = 1'b0;
      cur_v    = 1'b0;
      cur_a    = '0;
      cur_d    = '0;
      for (int j = 0; j < NWP; j++) begin
         slot_a[j] = '0;
         slot_d[j] = '0;
      end
      for (int s = 0; s < NREQ; s++) begin
         scan_idx = int'(rr_ptr) + s;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         cur_v = 1'b0;
         cur_a = '0;
         cur_d = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (i == scan_idx) begin
               cur_v = bus.req_valid[i];
               cur_a = req_a[i];
               cur_d = req_d[i];
            end
         end
         hit = 1'b0;
         for (int j = 0; j < NWP; j++) begin
            if (slot_en[j] && (slot_a[j] == cur_a)) hit = 1'b1;
         end
         if ((state == ST_RUN) && cur_v && (n_gr < NWP) && !hit) begin
            for (int i = 0; i < NREQ; i++) begin
               if (i == scan_idx) grant[i] = 1'b1;
            end
            for (int j = 0; j < NWP; j++) begin
               if (j == n_gr) begin
                  slot_en[j] = 1'b1;
                  slot_a[j]  = cur_a;
                  slot_d[j]  = cur_d;
               end
            end
            n_gr    = n_gr + 1;
            rr_next = (scan_idx == NREQ - 1) ? '0 : RR_W'(scan_idx + 1);
         end
      end
   end

   assign bus.req_ready = (state == ST_RUN) ? grant : '0;
   assign init_busy     = (state == ST_INIT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         rr_ptr      <= '0;
         bus.wp_en   <= '0;
         bus.wp_addr <= '0;
         bus.wp_data <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               bus.wp_en <= '1;
               for (int k = 0; k < NWP; k++) begin
                  bus.wp_addr[k*ADDR_W +: ADDR_W] <= ADDR_W'(int'(init_cnt) * NWP + k);
                  bus.wp_data[k*DATA_W +: DATA_W] <= '0;
               end
               if (init_cnt == CNT_W'(FILL_CYC - 1)) begin
                  state    <= ST_RUN;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               // Grants of this cycle still issue even if init_start is seen now.
               bus.wp_en <= slot_en;
               for (int k = 0; k < NWP; k++) begin
                  if (slot_en[k]) begin
                     bus.wp_addr[k*ADDR_W +: ADDR_W] <= slot_a[k];
                     bus.wp_data[k*DATA_W +: DATA_W] <= slot_d[k];
                  end
               end
               rr_ptr <= rr_next;
               if (init_start) begin
                  state    <= ST_INIT;
                  init_cnt <= '0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: fill sequence, round-robin order,
// address collisions, init_start during traffic, idle behaviour and reset mid-fill.
module tb_regfile_wb_arbiter;
   localparam int NREQ   = 6;
   localparam int NWP    = 4;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 65;
   localparam int DEPTH  = 128;

   logic clock      = 1'b0;
   logic reset_n    = 1'b1;
   logic init_start = 1'b0;
   logic init_busy;

   regfile_wb_arbiter_if #(.NREQ(NREQ), .NWP(NWP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   regfile_wb_arbiter #(
      .NREQ(NREQ), .NWP(NWP), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .init_start (init_start),
      .init_busy  (init_busy),
      .bus        (bus.slave)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   logic [ADDR_W-1:0] ra [NREQ];
   logic [DATA_W-1:0] rd [NREQ];
   logic [NREQ-1:0]   rv;

   function automatic logic [DATA_W-1:0] mkd(input int tag);
      return {1'b1, 32'(tag), 32'hC0DE_0000 ^ 32'(tag)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req_valid = rv;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i*ADDR_W +: ADDR_W] = ra[i];
         bus.req_data[i*DATA_W +: DATA_W] = rd[i];
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_port(input string tag, input int k, input int r);
      chk({tag, "_addr"}, 128'(bus.wp_addr[k*ADDR_W +: ADDR_W]), 128'(ra[r]));
      chk({tag, "_data"}, 128'(bus.wp_data[k*DATA_W +: DATA_W]), 128'(rd[r]));
   endtask

   task automatic check_fill(input int c, input logic busy_exp);
      chk("fill_en", 128'(bus.wp_en), 128'(4'hF));
      for (int k = 0; k < NWP; k++) begin
         chk("fill_addr", 128'(bus.wp_addr[k*ADDR_W +: ADDR_W]), 128'(c * NWP + k));
         chk("fill_data", 128'(bus.wp_data[k*DATA_W +: DATA_W]), 128'(0));
      end
      chk("fill_busy", 128'(init_busy), 128'(busy_exp));
      if (busy_exp) chk("fill_ready", 128'(bus.req_ready), 128'(0));
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         ra[i] = ADDR_W'(8 + i);
         rd[i] = mkd(i);
      end
      rv = '1;
      drive();

      // Reset values, observed without any clock edge.
      #1 reset_n = 1'b0;
      #2;
      chk("rst_busy",  128'(init_busy),     128'(1));
      chk("rst_en",    128'(bus.wp_en),     128'(0));
      chk("rst_addr",  128'(bus.wp_addr),   128'(0));
      chk("rst_data",  128'(bus.wp_data),   128'(0));
      chk("rst_ready", 128'(bus.req_ready), 128'(0));
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Fill: 32 cycles, ascending addresses, ready held low while requests are pending.
      for (int c = 0; c < DEPTH / NWP; c++) begin
         tick();
         check_fill(c, c < DEPTH / NWP - 1);
      end

      // First RUN cycle, rr_ptr=0, all six valid.
      chk("rr0_ready", 128'(bus.req_ready), 128'(6'b001111));
      tick();
      chk("rr0_en", 128'(bus.wp_en), 128'(4'hF));
      for (int k = 0; k < NWP; k++) chk_port("rr0_port", k, k);

      ra[0] = 7'h30; rd[0] = mkd(100);
      ra[1] = 7'h31; rd[1] = mkd(101);
      rv = 6'b110011;
      drive();
      #1;
      chk("rr4_ready", 128'(bus.req_ready), 128'(6'b110011));
      tick();
      chk("rr4_en", 128'(bus.wp_en), 128'(4'hF));
      chk_port("rr4_p0", 0, 4);
      chk_port("rr4_p1", 1, 5);
      chk_port("rr4_p2", 2, 0);
      chk_port("rr4_p3", 3, 1);

      // Single req5 wraps rr_ptr back to 0.
      rd[5] = mkd(105);
      rv = 6'b100000;
      drive();
      #1;
      chk("wrap_ready", 128'(bus.req_ready), 128'(6'b100000));
      tick();
      chk("wrap_en", 128'(bus.wp_en), 128'(4'b0001));
      chk_port("wrap_p0", 0, 5);

      // Collision: req0 and req2 both target 0x15; req0 is earlier in scan.
      ra[0] = 7'h15; rd[0] = mkd(200);
      ra[2] = 7'h15; rd[2] = mkd(202);
      rv = 6'b000101;
      drive();
      #1;
      chk("col_ready1", 128'(bus.req_ready), 128'(6'b000001));
      tick();
      chk("col_en1", 128'(bus.wp_en), 128'(4'b0001));
      chk_port("col_p0_first", 0, 0);
      rv = 6'b000100;
      drive();
      #1;
      chk("col_ready2", 128'(bus.req_ready), 128'(6'b000100));
      tick();
      chk("col_en2", 128'(bus.wp_en), 128'(4'b0001));
      chk_port("col_p0_second", 0, 2);

      // Idle for 5 cycles: nothing issued, port address holds.
      rv = '0;
      drive();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("idle_ready", 128'(bus.req_ready), 128'(0));
         tick();
         chk("idle_en", 128'(bus.wp_en), 128'(0));
         chk("idle_hold", 128'(bus.wp_addr[0 +: ADDR_W]), 128'(7'h15));
      end

      // Lone req3 granted at once; rr_ptr then 4.
      ra[3] = 7'h40; rd[3] = mkd(303);
      rv = 6'b001000;
      drive();
      #1;
      chk("lone_ready", 128'(bus.req_ready), 128'(6'b001000));
      tick();
      chk("lone_en", 128'(bus.wp_en), 128'(4'b0001));
      chk_port("lone_p0", 0, 3);

      for (int i = 0; i < NREQ; i++) begin
         ra[i] = ADDR_W'(8'h50 + i);
         rd[i] = mkd(400 + i);
      end
      rv = '1;
      drive();
      #1;
      chk("after_lone_ready", 128'(bus.req_ready), 128'(6'b110011));
      tick();
      chk_port("after_lone_p0", 0, 4);
      chk_port("after_lone_p3", 3, 1);

      // init_start alongside three grants (rr_ptr=2): order req2, req0, req1.
      rd[0] = mkd(500);
      rd[1] = mkd(501);
      rv = 6'b000111;
      init_start = 1'b1;
      drive();
      #1;
      chk("is_ready", 128'(bus.req_ready), 128'(6'b000111));
      tick();
      init_start = 1'b0;
      chk("is_en", 128'(bus.wp_en), 128'(4'b0111));
      chk_port("is_p0", 0, 2);
      chk_port("is_p1", 1, 0);
      chk_port("is_p2", 2, 1);
      chk("is_busy", 128'(init_busy), 128'(1));
      chk("is_ready_init", 128'(bus.req_ready), 128'(0));
      for (int c = 0; c < DEPTH / NWP; c++) begin
         tick();
         check_fill(c, c < DEPTH / NWP - 1);
      end
      chk("resume_ready", 128'(bus.req_ready), 128'(6'b000111));
      tick();
      chk("resume_en", 128'(bus.wp_en), 128'(4'b0111));
      chk_port("resume_p0", 0, 2);

      // Reset at INIT cycle 10 drops wp_en immediately; fill restarts at 0.
      rv = '0;
      drive();
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      chk("rst2_start_en", 128'(bus.wp_en), 128'(0));
      for (int c = 0; c < 10; c++) begin
         tick();
         check_fill(c, 1'b1);
      end
      reset_n = 1'b0;
      #1;
      chk("rst2_en",   128'(bus.wp_en),   128'(0));
      chk("rst2_busy", 128'(init_busy),   128'(1));
      chk("rst2_addr", 128'(bus.wp_addr), 128'(0));
      tick();
      reset_n = 1'b1;
      tick();
      check_fill(0, 1'b1);
      tick();
      check_fill(1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
